ex2_ex3_pair: RTL and testbench

EX2_EX3_PAIR -- requirements
Module: ex2_ex3_pair

---
 rtl/ex2_ex3_pair_pkg.sv | 25 ++
 rtl/ex2_ex3_pair_clk_div_en.sv | 64 ++++++
 rtl/ex2_ex3_pair.sv | 50 +++++
 tb/tb_ex2_ex3_pair.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ex2_ex3_pair_pkg.sv
// ============================================================================
// ex2_ex3_pair_pkg : shared types and helpers for the divider/counter pair
// Rev 1.0
// ============================================================================
`default_nettype none

package ex2_ex3_pair_pkg;

  typedef enum logic [1:0] {
    DIV_HOLD   = 2'd0,
    DIV_STEP   = 2'd1,
    DIV_TOGGLE = 2'd2,
    DIV_CLEAR  = 2'd3
  } div_op_e;

  // Phase counter width; never narrower than one bit (DIV=2 needs no count).
  function automatic int dcnt_width(input int div);
    int w;
    w = $clog2(div / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex2_ex3_pair_clk_div_en.sv
// ============================================================================
// clk_div_en : enable-gated divide-by-DIV square wave generator (registered)
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_en
  import ex2_ex3_pair_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic ld,
  input  logic clr,
  output logic fdclk
);

  localparam int             DW          = dcnt_width(DIV);
  localparam logic [DW-1:0]  C_HALF_LAST = DW'(DIV / 2 - 1);

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          fdclk_q, fdclk_d;
  div_op_e       op;

  always_comb begin
    op = DIV_HOLD;
    if (clr)                       op = DIV_CLEAR;
    else if (ld && dcnt_q == C_HALF_LAST) op = DIV_TOGGLE;
    else if (ld)                   op = DIV_STEP;
  end

  always_comb begin
    dcnt_d  = dcnt_q;
    fdclk_d = fdclk_q;
    case (op)
      DIV_CLEAR: begin
        dcnt_d  = '0;
        fdclk_d = 1'b0;
      end
      DIV_TOGGLE: begin
        dcnt_d  = '0;
        fdclk_d = ~fdclk_q;
      end
      DIV_STEP:  dcnt_d = dcnt_q + 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dcnt_q  <= '0;
      fdclk_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      fdclk_q <= fdclk_d;
    end
  end

  assign fdclk = fdclk_q;

endmodule

`default_nettype wire

// File: rtl/ex2_ex3_pair.sv
// ============================================================================
// ex2_ex3_pair : clock-enable divider plus independent CW-bit up-counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ex2_ex3_pair
  import ex2_ex3_pair_pkg::*;
#(
  parameter int DIV = 4,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic ld,
  input  logic c_up,
  input  logic clr,
  output logic fdclk,
  output logic o
);

  logic [CW-1:0] cnt_q, cnt_d;

  clk_div_en #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (ld),
    .clr   (clr),
    .fdclk (fdclk)
  );

  // Counter wraps naturally at 2^CW; clear beats count-up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (c_up) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o = &cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ex2_ex3_pair.sv
// ============================================================================
// tb_ex2_ex3_pair : randomized scoreboard bench for two parameterizations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex2_ex3_pair;

  typedef struct {
    bit fd;
    bit o;
  } exp_t;

  logic clk;
  logic rst_b;
  logic ld;
  logic c_up;
  logic clr;
  logic fd0, o0, fd1, o1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state: enabled edges since clear (mod DIV) and counter value
  int div_of[2] = '{4, 6};
  int cw_of[2]  = '{4, 3};
  int en_edges[2];
  int cnt[2];

  ex2_ex3_pair #(.DIV(4), .CW(4)) u_dut0 (
    .clk(clk), .rst_b(rst_b), .ld(ld), .c_up(c_up), .clr(clr),
    .fdclk(fd0), .o(o0)
  );

  ex2_ex3_pair #(.DIV(6), .CW(3)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .ld(ld), .c_up(c_up), .clr(clr),
    .fdclk(fd1), .o(o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_out(input int inst);
    exp_t e;
    e.fd = ((en_edges[inst] / (div_of[inst] / 2)) % 2) == 1;
    e.o  = (cnt[inst] == (1 << cw_of[inst]) - 1);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      en_edges[i] = 0;
      cnt[i]      = 0;
    end
  endtask

  task automatic model_edge(input bit m_ld, input bit m_cup, input bit m_clr);
    for (int i = 0; i < 2; i++) begin
      if (m_clr) begin
        en_edges[i] = 0;
        cnt[i]      = 0;
      end else begin
        if (m_ld)  en_edges[i] = (en_edges[i] + 1) % div_of[i];
        if (m_cup) cnt[i] = (cnt[i] + 1) % (1 << cw_of[i]);
      end
    end
  endtask

  task automatic check(input string name, input int inst, input logic a_fd,
                       input logic a_o, input exp_t e);
    checks++;
    if (a_fd !== e.fd || a_o !== e.o) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got fdclk=%0b o=%0b, required fdclk=%0b o=%0b",
               name, inst, $time, a_fd, a_o, e.fd, e.o);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled just after the edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("edge", 0, fd0, o0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("edge", 1, fd1, o1, e);
    end
  end

  initial begin
    exp_t z;
    bit   do_rst;
    z.fd = 1'b0;
    z.o  = 1'b0;

    rst_b = 1'b0;
    ld    = 1'b1;
    c_up  = 1'b1;
    clr   = 1'b1;
    #2;
    check("reset_state", 0, fd0, o0, z);
    check("reset_state", 1, fd1, o1, z);
    rst_b = 1'b0;
    ld    = 1'b0;
    c_up  = 1'b0;
    clr   = 1'b0;
    #1;
    rst_b = 1'b1;
    model_reset();

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #2;
      do_rst = (cyc > 40) && ($urandom % 50 == 0);
      if (do_rst) begin
        rst_b = 1'b0;
        #1;
        check("async_reset", 0, fd0, o0, z);
        check("async_reset", 1, fd1, o1, z);
        model_reset();
        #1;
        rst_b = 1'b1;
      end
      if (cyc < 40) begin
        // free-running start: exercises first rise, full period and wrap
        ld   = 1'b1;
        c_up = 1'b1;
        clr  = (cyc == 25);
      end else begin
        ld   = ($urandom % 4) != 0;
        c_up = ($urandom % 4) != 0;
        clr  = ($urandom % 20) == 0;
      end
      model_edge(ld, c_up, clr);
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
    end

    @(posedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
